conv_window_ctrl: RTL and testbench

Sequencing controller for the 3x3 convolution `multiplier` in the user project area. It accepts a 9-word kernel followed by a row-major pixel stream. It builds each 3x3 window with two internal line buffers and drives the multiplier's `out_en`/`shift_in`/`kernel_in`. It then collects `pixel_out` into a small result FIFO presented as a valid/ready output stream.

---
 rtl/conv_pkg.sv | 15 +
 rtl/conv_res_fifo.sv | 71 +++++++
 rtl/conv_window_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_conv_window_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants and FSM state encoding for the 3x3 convolution window controller.
package conv_pkg;

    localparam int BITS        = 32;
    localparam int KERNEL_SIZE = 3;
    localparam int KWORDS      = 9;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_K,
        STREAM,
        DRAIN
    } state_e;

endpackage

// File: rtl/conv_res_fifo.sv
// Result FIFO: registered storage, data visible the cycle after a push; push and pop may coincide at any
// occupancy, a push into a full FIFO is only taken together with a pop.
module conv_res_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CNT_FULL) || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign valid_o = (count_q != '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/conv_window_ctrl.sv
// Builds 3x3 windows from a row-major pixel stream for an external multiplier; window pixel to out_valid
// takes 2+MULT_LAT cycles, input is credit-throttled so results in flight always fit in the FIFO.
module conv_window_ctrl
    import conv_pkg::*;
#(
    parameter int BITS        = conv_pkg::BITS,
    parameter int KERNEL_SIZE = conv_pkg::KERNEL_SIZE,
    parameter int IMG_W_MAX   = 64,
    parameter int DIM_W       = 8,
    parameter int MULT_LAT    = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      start,
    input  logic [DIM_W-1:0]                          cfg_width,
    input  logic [DIM_W-1:0]                          cfg_height,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [BITS-1:0]                           in_data,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [BITS-1:0]                           out_data,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      cfg_err,
    output logic                                      mul_out_en,
    output logic [KERNEL_SIZE*KERNEL_SIZE*BITS-1:0]   mul_shift_in,
    output logic [KERNEL_SIZE*KERNEL_SIZE*BITS-1:0]   mul_kernel_in,
    input  logic [BITS-1:0]                           mul_pixel_in
);

    localparam int KW    = KERNEL_SIZE * KERNEL_SIZE;
    localparam int LB_AW = $clog2(IMG_W_MAX);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [DIM_W-1:0] DIM_ONE   = DIM_W'(1);
    localparam logic [DIM_W-1:0] DIM_TWO   = DIM_W'(2);
    localparam logic [DIM_W-1:0] DIM_THREE = DIM_W'(3);
    localparam logic [DIM_W:0]   W_MAX     = (DIM_W + 1)'(IMG_W_MAX);
    localparam logic [CNT_W:0]   CREDITS   = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [3:0]       KIDX_LAST = 4'(KWORDS - 1);

    state_e              state_q, state_d;
    logic [DIM_W-1:0]    width_q, width_d;
    logic [DIM_W-1:0]    height_q, height_d;
    logic [DIM_W-1:0]    col_q, col_d;
    logic [DIM_W-1:0]    row_q, row_d;
    logic [3:0]          kidx_q, kidx_d;
    logic [KW*BITS-1:0]  kernel_q, kernel_d;
    logic [KW*BITS-1:0]  win_q, win_d;
    logic                win_en_q, win_en_d;
    logic                cfg_err_q, cfg_err_d;
    logic [CNT_W-1:0]    inflight_q, inflight_d;
    logic [MULT_LAT-1:0] lat_q;
    logic [MULT_LAT:0]   lat_ext;

    logic [BITS-1:0]     lb0_q [IMG_W_MAX];
    logic [BITS-1:0]     lb1_q [IMG_W_MAX];
    logic [BITS-1:0]     lb0_rd;
    logic [BITS-1:0]     lb1_rd;
    logic [LB_AW-1:0]    col_idx;

    logic [CNT_W-1:0]    fifo_count;
    logic                res_push;
    logic                credit_ok;
    logic                accept;
    logic                pix_acc;
    logic                win_hit;
    logic                last_col;
    logic                last_row;
    logic                cfg_ok;

    assign col_idx   = col_q[LB_AW-1:0];
    assign lb0_rd    = lb0_q[col_idx];
    assign lb1_rd    = lb1_q[col_idx];
    assign accept    = in_valid && in_ready;
    assign pix_acc   = accept && (state_q == STREAM);
    assign win_hit   = pix_acc && (row_q >= DIM_TWO) && (col_q >= DIM_TWO);
    assign last_col  = (col_q == width_q - DIM_ONE);
    assign last_row  = (row_q == height_q - DIM_ONE);
    assign cfg_ok    = (cfg_width >= DIM_THREE) && ({1'b0, cfg_width} <= W_MAX)
                       && (cfg_height >= DIM_THREE);
    // Results already pushed plus those still inside the multiplier must never exceed the FIFO.
    assign credit_ok = ({1'b0, fifo_count} + {1'b0, inflight_q}) < CREDITS;
    assign lat_ext   = {lat_q, win_en_q};
    assign res_push  = lat_q[MULT_LAT-1];

    always_comb begin
        state_d   = state_q;
        width_d   = width_q;
        height_d  = height_q;
        col_d     = col_q;
        row_d     = row_q;
        kidx_d    = kidx_q;
        kernel_d  = kernel_q;
        win_d     = win_q;
        win_en_d  = win_hit;
        cfg_err_d = 1'b0;
        in_ready  = 1'b0;
        done      = 1'b0;
        busy      = (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        width_d  = cfg_width;
                        height_d = cfg_height;
                        col_d    = '0;
                        row_d    = '0;
                        kidx_d   = '0;
                        state_d  = LOAD_K;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            LOAD_K: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    kernel_d[kidx_q*BITS +: BITS] = in_data;
                    kidx_d = kidx_q + 4'd1;
                    if (kidx_q == KIDX_LAST) begin
                        state_d = STREAM;
                    end
                end
            end
            STREAM: begin
                in_ready = credit_ok;
                if (pix_acc) begin
                    // Row 0 is the oldest row, column 0 the oldest column.
                    for (int r = 0; r < KERNEL_SIZE; r++) begin
                        win_d[(r*3+0)*BITS +: BITS] = win_q[(r*3+1)*BITS +: BITS];
                        win_d[(r*3+1)*BITS +: BITS] = win_q[(r*3+2)*BITS +: BITS];
                    end
                    win_d[2*BITS +: BITS] = lb1_rd;
                    win_d[5*BITS +: BITS] = lb0_rd;
                    win_d[8*BITS +: BITS] = in_data;
                    if (last_col) begin
                        col_d = '0;
                        row_d = row_q + DIM_ONE;
                        if (last_row) begin
                            state_d = DRAIN;
                        end
                    end else begin
                        col_d = col_q + DIM_ONE;
                    end
                end
            end
            DRAIN: begin
                if ((inflight_q == '0) && (fifo_count == '0)) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        unique case ({win_hit, res_push})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            width_q    <= '0;
            height_q   <= '0;
            col_q      <= '0;
            row_q      <= '0;
            kidx_q     <= '0;
            kernel_q   <= '0;
            win_q      <= '0;
            win_en_q   <= 1'b0;
            cfg_err_q  <= 1'b0;
            inflight_q <= '0;
            lat_q      <= '0;
        end else begin
            state_q    <= state_d;
            width_q    <= width_d;
            height_q   <= height_d;
            col_q      <= col_d;
            row_q      <= row_d;
            kidx_q     <= kidx_d;
            kernel_q   <= kernel_d;
            win_q      <= win_d;
            win_en_q   <= win_en_d;
            cfg_err_q  <= cfg_err_d;
            inflight_q <= inflight_d;
            lat_q      <= lat_ext[MULT_LAT-1:0];
        end
    end

    // Line buffers need no reset: every entry is rewritten before a window can use it.
    always_ff @(posedge clk) begin
        if (pix_acc) begin
            lb1_q[col_idx] <= lb0_rd;
            lb0_q[col_idx] <= in_data;
        end
    end

    conv_res_fifo #(
        .WIDTH (BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_res_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (res_push),
        .push_data_i (mul_pixel_in),
        .pop_i       (out_ready),
        .valid_o     (out_valid),
        .data_o      (out_data),
        .count_o     (fifo_count)
    );

    assign cfg_err       = cfg_err_q;
    assign mul_out_en    = win_en_q;
    assign mul_shift_in  = win_q;
    assign mul_kernel_in = kernel_q;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Directed bench for conv_window_ctrl with a behavioural one-cycle multiplier model.
module tb_conv_window_ctrl;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [7:0]   cfg_width;
    logic [7:0]   cfg_height;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         busy;
    logic         done;
    logic         cfg_err;
    logic         mul_out_en;
    logic [287:0] mul_shift_in;
    logic [287:0] mul_kernel_in;
    logic [31:0]  mul_pixel_in;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int en_cnt = 0;
    int first_ov = -1;
    int last_acc_cyc = 0;
    logic [31:0] q[$];

    conv_window_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .cfg_width     (cfg_width),
        .cfg_height    (cfg_height),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .busy          (busy),
        .done          (done),
        .cfg_err       (cfg_err),
        .mul_out_en    (mul_out_en),
        .mul_shift_in  (mul_shift_in),
        .mul_kernel_in (mul_kernel_in),
        .mul_pixel_in  (mul_pixel_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] msum;
    always @(posedge clk) begin
        if (mul_out_en) begin
            msum = 32'd0;
            for (int k = 0; k < 9; k++) begin
                msum = msum + mul_shift_in[k*32 +: 32] * mul_kernel_in[k*32 +: 32];
            end
            mul_pixel_in <= msum;
        end
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (out_valid && out_ready) q.push_back(out_data);
        if (done) done_cnt = done_cnt + 1;
        if (cfg_err) err_cnt = err_cnt + 1;
        if (mul_out_en) en_cnt = en_cnt + 1;
        if (out_valid && first_ov < 0) first_ov = cyc;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    function automatic logic [287:0] kv_ones();
        logic [287:0] v;
        for (int k = 0; k < 9; k++) v[k*32 +: 32] = 32'd1;
        return v;
    endfunction

    function automatic logic [287:0] kv_ident();
        logic [287:0] v;
        v = '0;
        v[4*32 +: 32] = 32'd1;
        return v;
    endfunction

    task automatic drive_word(input logic [31:0] d, input int budget, output bit ok);
        in_valid = 1'b1;
        in_data  = d;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (in_ready) begin
                @(negedge clk);
                ok = 1'b1;
                last_acc_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic start_frame(input int w, input int h, input logic [287:0] kv, output bit ok);
        bit wok;
        ok = 1'b1;
        cfg_width  = 8'(w);
        cfg_height = 8'(h);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 9; k++) begin
            drive_word(kv[k*32 +: 32], 20, wok);
            ok = ok & wok;
        end
    endtask

    task automatic feed(input int base, input int from, input int to, output bit ok);
        bit wok;
        ok = 1'b1;
        for (int i = from; i <= to; i++) begin
            drive_word(32'(base + i), 40, wok);
            ok = ok & wok;
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int d0;
        d0 = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_cnt != d0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic clear_mon();
        q.delete();
        en_cnt = 0;
        done_cnt = 0;
        err_cnt = 0;
        first_ov = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || cfg_err !== 1'b0) begin errors++; $display("FAIL reset_status got=%b%b%b exp=000", busy, done, cfg_err); end
        checks++; if (mul_out_en !== 1'b0) begin errors++; $display("FAIL reset_mul_out_en got=%b exp=0", mul_out_en); end
        checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL reset_out_data got=%0d exp=0", out_data); end
        checks++; if (mul_shift_in !== '0 || mul_kernel_in !== '0) begin errors++; $display("FAIL reset_mul_buses got=%h/%h exp=0", mul_shift_in, mul_kernel_in); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ones_4x4();
        bit ok, aok;
        int acc11;
        logic [287:0] ew;
        int wv [9] = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
        logic [31:0] ex [4] = '{32'd54, 32'd63, 32'd90, 32'd99};
        clear_mon();
        out_ready = 1'b1;
        aok = 1'b1;
        start_frame(4, 4, kv_ones(), ok); aok &= ok;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ones_busy got=%b exp=1", busy); end
        checks++; if (mul_kernel_in !== kv_ones()) begin errors++; $display("FAIL ones_kernel got=%h exp=%h", mul_kernel_in, kv_ones()); end
        feed(0, 1, 10, ok); aok &= ok;
        checks++; if (en_cnt !== 0) begin errors++; $display("FAIL ones_early_en got=%0d exp=0", en_cnt); end
        feed(0, 11, 11, ok); aok &= ok;
        acc11 = last_acc_cyc;
        for (int k = 0; k < 9; k++) ew[k*32 +: 32] = 32'(wv[k]);
        checks++; if (mul_out_en !== 1'b1) begin errors++; $display("FAIL ones_en_after_window got=%b exp=1", mul_out_en); end
        checks++; if (mul_shift_in !== ew) begin errors++; $display("FAIL ones_window got=%h exp=%h", mul_shift_in, ew); end
        feed(0, 12, 16, ok); aok &= ok;
        wait_done(50, ok); aok &= ok;
        checks++; if (!aok) begin errors++; $display("FAIL ones_handshake_timeout got=0 exp=1"); end
        checks++; if (first_ov - acc11 !== 3) begin errors++; $display("FAIL ones_latency got=%0d exp=3", first_ov - acc11); end
        checks++; if (q.size() !== 4) begin errors++; $display("FAIL ones_count got=%0d exp=4", q.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= q.size() || q[i] !== ex[i]) begin errors++; $display("FAIL ones_out%0d got=%0d exp=%0d", i, (i < q.size()) ? q[i] : 32'hx, ex[i]); end
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done_cnt !== 1 || en_cnt !== 4) begin errors++; $display("FAIL ones_end busy=%b done=%0d en=%0d exp=0/1/4", busy, done_cnt, en_cnt); end
    endtask

    task automatic test_ident_5x3();
        bit ok, aok;
        logic [31:0] ex [3] = '{32'd7, 32'd8, 32'd9};
        clear_mon();
        out_ready = 1'b1;
        aok = 1'b1;
        start_frame(5, 3, kv_ident(), ok); aok &= ok;
        checks++; if (mul_kernel_in !== kv_ident()) begin errors++; $display("FAIL ident_kernel got=%h exp=%h", mul_kernel_in, kv_ident()); end
        feed(0, 1, 15, ok); aok &= ok;
        wait_done(50, ok); aok &= ok;
        checks++; if (!aok) begin errors++; $display("FAIL ident_handshake_timeout got=0 exp=1"); end
        checks++; if (q.size() !== 3 || en_cnt !== 3) begin errors++; $display("FAIL ident_count got=%0d/%0d exp=3/3", q.size(), en_cnt); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= q.size() || q[i] !== ex[i]) begin errors++; $display("FAIL ident_out%0d got=%0d exp=%0d", i, (i < q.size()) ? q[i] : 32'hx, ex[i]); end
        end
    endtask

    task automatic test_backpressure();
        bit ok, aok;
        logic [31:0] ex [4] = '{32'd54, 32'd63, 32'd90, 32'd99};
        clear_mon();
        out_ready = 1'b0;
        aok = 1'b1;
        start_frame(4, 4, kv_ones(), ok); aok &= ok;
        feed(0, 1, 16, ok); aok &= ok;
        repeat (20) @(negedge clk);
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL bp_hold rdy=%b vld=%b busy=%b exp=0/1/1", in_ready, out_valid, busy); end
        checks++; if (out_data !== 32'd54) begin errors++; $display("FAIL bp_head got=%0d exp=54", out_data); end
        checks++; if (done_cnt !== 0 || q.size() !== 0) begin errors++; $display("FAIL bp_early done=%0d q=%0d exp=0/0", done_cnt, q.size()); end
        out_ready = 1'b1;
        wait_done(50, ok); aok &= ok;
        checks++; if (!aok) begin errors++; $display("FAIL bp_handshake_timeout got=0 exp=1"); end
        checks++; if (q.size() !== 4) begin errors++; $display("FAIL bp_count got=%0d exp=4", q.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= q.size() || q[i] !== ex[i]) begin errors++; $display("FAIL bp_out%0d got=%0d exp=%0d", i, (i < q.size()) ? q[i] : 32'hx, ex[i]); end
        end
    endtask

    task automatic test_credit_stall();
        bit ok, aok;
        int stalled;
        logic [31:0] ex [6] = '{32'd63, 32'd72, 32'd81, 32'd108, 32'd117, 32'd126};
        clear_mon();
        out_ready = 1'b0;
        aok = 1'b1;
        start_frame(5, 4, kv_ones(), ok); aok &= ok;
        feed(0, 1, 18, ok); aok &= ok;
        in_valid = 1'b1;
        in_data  = 32'd19;
        stalled  = 0;
        for (int i = 0; i < 10; i++) begin
            if (in_ready === 1'b0) stalled++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++; if (stalled !== 10) begin errors++; $display("FAIL stall_cycles got=%0d exp=10", stalled); end
        checks++; if (out_valid !== 1'b1 || q.size() !== 0) begin errors++; $display("FAIL stall_fifo vld=%b q=%0d exp=1/0", out_valid, q.size()); end
        out_ready = 1'b1;
        feed(0, 19, 20, ok); aok &= ok;
        wait_done(50, ok); aok &= ok;
        checks++; if (!aok) begin errors++; $display("FAIL stall_handshake_timeout got=0 exp=1"); end
        checks++; if (q.size() !== 6) begin errors++; $display("FAIL stall_count got=%0d exp=6", q.size()); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= q.size() || q[i] !== ex[i]) begin errors++; $display("FAIL stall_out%0d got=%0d exp=%0d", i, (i < q.size()) ? q[i] : 32'hx, ex[i]); end
        end
    endtask

    task automatic test_cfg_err();
        clear_mon();
        cfg_width  = 8'd2;
        cfg_height = 8'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfgerr_pulse got=%b exp=1", cfg_err); end
        checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL cfgerr_idle busy=%b rdy=%b exp=0/0", busy, in_ready); end
        @(negedge clk);
        checks++; if (cfg_err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL cfgerr_one_cycle err=%b busy=%b exp=0/0", cfg_err, busy); end
        cfg_width  = 8'd65;
        cfg_height = 8'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++; if (err_cnt !== 2 || busy !== 1'b0) begin errors++; $display("FAIL cfgerr_wide err_cnt=%0d busy=%b exp=2/0", err_cnt, busy); end
    endtask

    task automatic test_reset_mid();
        bit ok, aok;
        logic [31:0] ex [4] = '{32'd954, 32'd963, 32'd990, 32'd999};
        clear_mon();
        out_ready = 1'b1;
        aok = 1'b1;
        start_frame(4, 4, kv_ones(), ok); aok &= ok;
        feed(0, 1, 7, ok); aok &= ok;
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || mul_kernel_in !== '0) begin errors++; $display("FAIL midrst_clear busy=%b rdy=%b k=%h exp=0/0/0", busy, in_ready, mul_kernel_in); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_mon();
        start_frame(4, 4, kv_ones(), ok); aok &= ok;
        feed(100, 1, 16, ok); aok &= ok;
        wait_done(50, ok); aok &= ok;
        checks++; if (!aok) begin errors++; $display("FAIL midrst_handshake_timeout got=0 exp=1"); end
        checks++; if (q.size() !== 4 || done_cnt !== 1) begin errors++; $display("FAIL midrst_count q=%0d done=%0d exp=4/1", q.size(), done_cnt); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= q.size() || q[i] !== ex[i]) begin errors++; $display("FAIL midrst_out%0d got=%0d exp=%0d", i, (i < q.size()) ? q[i] : 32'hx, ex[i]); end
        end
    endtask

    task automatic test_start_ignored();
        bit ok, aok;
        logic [31:0] ex [4] = '{32'd54, 32'd63, 32'd90, 32'd99};
        clear_mon();
        out_ready = 1'b1;
        aok = 1'b1;
        start_frame(4, 4, kv_ones(), ok); aok &= ok;
        feed(0, 1, 5, ok); aok &= ok;
        cfg_width  = 8'd2;
        cfg_height = 8'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        feed(0, 6, 16, ok); aok &= ok;
        wait_done(50, ok); aok &= ok;
        repeat (5) @(negedge clk);
        checks++; if (!aok) begin errors++; $display("FAIL ign_handshake_timeout got=0 exp=1"); end
        checks++; if (err_cnt !== 0 || done_cnt !== 1 || busy !== 1'b0) begin errors++; $display("FAIL ign_status err=%0d done=%0d busy=%b exp=0/1/0", err_cnt, done_cnt, busy); end
        checks++; if (q.size() !== 4) begin errors++; $display("FAIL ign_count got=%0d exp=4", q.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= q.size() || q[i] !== ex[i]) begin errors++; $display("FAIL ign_out%0d got=%0d exp=%0d", i, (i < q.size()) ? q[i] : 32'hx, ex[i]); end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        cfg_width  = 8'd0;
        cfg_height = 8'd0;
        in_valid   = 1'b0;
        in_data    = 32'd0;
        out_ready  = 1'b0;
        mul_pixel_in = 32'd0;
        @(negedge clk);
        test_reset();
        test_ones_4x4();
        test_ident_5x3();
        test_backpressure();
        test_credit_stall();
        test_cfg_err();
        test_reset_mid();
        test_start_ignored();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
